// File: rtl/set_job_fifo.sv
// set_job_fifo: queue of (central, radius) job pairs feeding the SET engine.
// The host can load further jobs while the engine works on the presented head.
// The head entry is held in dedicated output registers so central_buf_o and
// r_buf_o come straight from flops. Status flags are also registered, so
// push_ready_o has no combinational path from pop_i.
module set_job_fifo #(
  parameter int CENTRAL_W = 24,
  parameter int RADIUS_W  = 12,
  parameter int DEPTH     = 4,
  parameter int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clear_i,
  input  logic                 push_i,
  input  logic [CENTRAL_W-1:0] central_i,
  input  logic [RADIUS_W-1:0]  r_i,
  output logic                 push_ready_o,
  input  logic                 pop_i,
  output logic                 valid_o,
  output logic [CENTRAL_W-1:0] central_buf_o,
  output logic [RADIUS_W-1:0]  r_buf_o,
  output logic [CNT_W-1:0]     count_o,
  output logic                 full_o,
  output logic                 empty_o,
  output logic                 overflow_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Storage for queued jobs; the slot at rd_ptr mirrors the head registers.
  logic [CENTRAL_W-1:0] mem_central [DEPTH];
  logic [RADIUS_W-1:0]  mem_r       [DEPTH];

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W-1:0] wr_ptr_next, rd_ptr_next;
  logic [CNT_W-1:0] count_next;
  logic [CNT_W-1:0] count_after_pop;
  logic             push_acc, pop_acc, push_drop;
  logic             valid_next;
  logic [CENTRAL_W-1:0] central_next;
  logic [RADIUS_W-1:0]  r_next;

  // Accept decisions depend only on registered state, never on the other request.
  assign push_acc  = push_i && (count_o != CNT_FULL);
  assign push_drop = push_i && (count_o == CNT_FULL);
  assign pop_acc   = pop_i && valid_o;

  // Next pointers, occupancy and head contents for the coming edge.
  always_comb begin
    // NOTE: combinational blocks use blocking '=' and give every output a
    // default first, so no path leaves a signal unassigned (no latch).
    wr_ptr_next     = wr_ptr;
    rd_ptr_next     = rd_ptr;
    count_after_pop = count_o;
    count_next      = count_o;
    valid_next      = valid_o;
    central_next    = central_buf_o;
    r_next          = r_buf_o;

    if (pop_acc) begin
      rd_ptr_next     = rd_ptr + PTR_W'(1);
      count_after_pop = count_o - CNT_ONE;
    end
    count_next = count_after_pop;
    if (push_acc) begin
      wr_ptr_next = wr_ptr + PTR_W'(1);
      count_next  = count_after_pop + CNT_ONE;
    end

    valid_next = (count_next != '0);
    if (count_next != '0) begin
      if (count_after_pop == '0) begin
        // The queue would otherwise be empty: the pushed job becomes the head.
        central_next = central_i;
        r_next       = r_i;
      end else begin
        central_next = mem_central[rd_ptr_next];
        r_next       = mem_r[rd_ptr_next];
      end
    end
    // When nothing remains, the head registers keep the last presented job.
  end

  // Job storage write port; contents are only meaningful between the pointers.
  always_ff @(posedge clk_i) begin
    // NOTE: the storage array has no reset; stale slots are never presented
    // because the pointers and count are reset, and leaving it unreset keeps
    // the array mappable to plain RAM/register files.
    if (push_acc && !rst_i && !clear_i) begin
      mem_central[wr_ptr] <= central_i;
      mem_r[wr_ptr]       <= r_i;
    end
  end

  // Control, head and status registers; reset and clear take priority.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking '<=' so every flop samples
    // the pre-edge values regardless of statement order.
    if (rst_i || clear_i) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count_o       <= '0;
      valid_o       <= 1'b0;
      central_buf_o <= '0;
      r_buf_o       <= '0;
      full_o        <= 1'b0;
      empty_o       <= 1'b1;
      push_ready_o  <= 1'b1;
      overflow_o    <= 1'b0;
    end else begin
      wr_ptr        <= wr_ptr_next;
      rd_ptr        <= rd_ptr_next;
      count_o       <= count_next;
      valid_o       <= valid_next;
      central_buf_o <= central_next;
      r_buf_o       <= r_next;
      full_o        <= (count_next == CNT_FULL);
      empty_o       <= (count_next == '0);
      push_ready_o  <= (count_next != CNT_FULL);
      if (push_drop) begin
        overflow_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_set_job_fifo.sv
// Directed testbench for set_job_fifo with a queue-based reference model.
module tb_set_job_fifo;

  localparam int CW    = 24;
  localparam int RW    = 12;
  localparam int DEPTH = 4;
  localparam int CNTW  = $clog2(DEPTH + 1);

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b0;
  logic            clear_i = 1'b0;
  logic            push_i = 1'b0;
  logic [CW-1:0]   central_i = '0;
  logic [RW-1:0]   r_i = '0;
  logic            push_ready_o;
  logic            pop_i = 1'b0;
  logic            valid_o;
  logic [CW-1:0]   central_buf_o;
  logic [RW-1:0]   r_buf_o;
  logic [CNTW-1:0] count_o;
  logic            full_o, empty_o, overflow_o;

  set_job_fifo #(.CENTRAL_W(CW), .RADIUS_W(RW), .DEPTH(DEPTH), .CNT_W(CNTW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i),
    .push_i(push_i), .central_i(central_i), .r_i(r_i), .push_ready_o(push_ready_o),
    .pop_i(pop_i), .valid_o(valid_o), .central_buf_o(central_buf_o), .r_buf_o(r_buf_o),
    .count_o(count_o), .full_o(full_o), .empty_o(empty_o), .overflow_o(overflow_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: scoreboard of jobs in flight, sticky overflow, held head.
  logic [CW+RW-1:0] sb[$];
  logic             exp_ovf = 1'b0;
  logic [CW+RW-1:0] last_head = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare all outputs against the model (called #1 after an edge).
  task automatic check_state(input string tag);
    logic [CW+RW-1:0] exp_head;
    exp_head = (sb.size() > 0) ? sb[0] : last_head;
    check({tag, ".count"}, 64'(count_o), 64'(sb.size()));
    check({tag, ".valid"}, 64'(valid_o), 64'(sb.size() > 0));
    check({tag, ".empty"}, 64'(empty_o), 64'(sb.size() == 0));
    check({tag, ".full"},  64'(full_o),  64'(sb.size() == DEPTH));
    check({tag, ".ready"}, 64'(push_ready_o), 64'(sb.size() < DEPTH));
    check({tag, ".ovf"},   64'(overflow_o), 64'(exp_ovf));
    check({tag, ".head"},  64'({central_buf_o, r_buf_o}), 64'(exp_head));
  endtask

  // One clock cycle of stimulus; the scoreboard is popped when the DUT hands
  // over its head, and pushed when a job is accepted.
  task automatic cycle(input string tag, input logic psh, input logic [CW-1:0] c,
                       input logic [RW-1:0] r, input logic pp, input logic clr,
                       input logic rst = 1'b0);
    int pre;
    pre = sb.size();
    rst_i   = rst;
    clear_i = clr;
    push_i  = psh;
    pop_i   = pp;
    // Off-push cycles carry junk data that must be ignored.
    central_i = psh ? c : CW'($urandom);
    r_i       = psh ? r : RW'($urandom);
    if (rst || clr) begin
      sb.delete();
      exp_ovf   = 1'b0;
      last_head = '0;
    end else begin
      if (pp && pre > 0) begin
        check({tag, ".pop_data"}, 64'({central_buf_o, r_buf_o}), 64'(sb[0]));
        void'(sb.pop_front());
      end
      if (psh) begin
        if (pre < DEPTH) sb.push_back({c, r});
        else exp_ovf = 1'b1;
      end
    end
    @(posedge clk_i);
    #1;
    rst_i = 1'b0; clear_i = 1'b0; push_i = 1'b0; pop_i = 1'b0;
    if (sb.size() > 0) last_head = sb[0];
    check_state(tag);
  endtask

  initial begin
    logic [CW-1:0] c;
    logic [RW-1:0] r;
    #1;

    // Reset held two cycles with push_i asserted: push must be ignored.
    cycle("rst0", 1'b1, 24'hDEAD01, 12'h001, 1'b0, 1'b0, 1'b1);
    cycle("rst1", 1'b1, 24'hDEAD02, 12'h002, 1'b0, 1'b0, 1'b1);

    // FIFO ordering, one-edge latency, then drain with hold of last head.
    cycle("ord_p0", 1'b1, 24'h123456, 12'h321, 1'b0, 1'b0);
    cycle("ord_p1", 1'b1, 24'hABCDEF, 12'h0F0, 1'b0, 1'b0);
    cycle("ord_p2", 1'b1, 24'h000111, 12'h555, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle("ord_pop", 1'b0, '0, '0, 1'b1, 1'b0);
    check("hold_head", 64'({central_buf_o, r_buf_o}), 64'({24'h000111, 12'h555}));

    // Five pushes into a DEPTH=4 queue: fifth dropped, overflow sticks.
    for (int i = 0; i < 5; i++)
      cycle("full_push", 1'b1, CW'(24'h100 + i), RW'(i + 1), 1'b0, 1'b0);
    // Full with pop and push together: pop taken, push dropped.
    cycle("full_pp", 1'b1, 24'hBAD000, 12'hBAD, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle("full_drain", 1'b0, '0, '0, 1'b1, 1'b0);
    cycle("clr_ovf", 1'b0, '0, '0, 1'b0, 1'b1);

    // Simultaneous push+pop at count 1 then count 2, across several wraps.
    cycle("pp_seed", 1'b1, 24'h200000, 12'h200, 1'b0, 1'b0);
    for (int i = 1; i <= 20; i++) begin
      c = CW'(24'h200000 + i); r = RW'(12'h200 + i);
      cycle("pp_c1", 1'b1, c, r, 1'b1, 1'b0);
    end
    cycle("pp_seed2", 1'b1, 24'h300000, 12'h300, 1'b0, 1'b0);
    for (int i = 1; i <= 20; i++) begin
      c = CW'(24'h300000 + i); r = RW'(12'h300 + i);
      cycle("pp_c2", 1'b1, c, r, 1'b1, 1'b0);
    end

    // Clear mid-operation with push and pop asserted in the same cycle.
    cycle("clr_fill", 1'b1, 24'h400001, 12'h401, 1'b0, 1'b0);
    check("clr_pre_count", 64'(count_o), 64'd3);
    cycle("clr", 1'b1, 24'h4BAD00, 12'h4BA, 1'b1, 1'b1);
    cycle("clr_push", 1'b1, 24'h500001, 12'h501, 1'b0, 1'b0);
    cycle("clr_pop", 1'b0, '0, '0, 1'b1, 1'b0);

    // Pop on empty: no state change.
    for (int i = 0; i < 5; i++) cycle("pop_empty", 1'b0, '0, '0, 1'b1, 1'b0);
    check("empty_hold", 64'({central_buf_o, r_buf_o}), 64'({24'h500001, 12'h501}));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
